div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Iterative radix-2 integer divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Sits between the register read stage and the register file write port.
- Takes rs1/rs2 operand values and the destination index, runs a multi-cycle restoring division, and delivers one write-back beat (enable, rd address, data) that drives register file write port 3.

Parameters:
- DATA_WIDTH, 32, operand/result width; also the iteration count.
- ADDR_WIDTH, 5, register index width.

Ports:
- clk  input  1  clock.
- arst  input  1  reset; synchronous, active-high, sampled on posedge clk.
- i_start  input  1  request; accepted only when o_busy=0.
- i_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
- i_rs1_data  input  DATA_WIDTH  dividend.
- i_rs2_data  input  DATA_WIDTH  divisor.
- i_rd_addr  input  ADDR_WIDTH  destination register index.
- o_busy  output  1  high while in CALC or FIX.
- o_done  output  1  one-cycle completion pulse.
- o_write_en  output  1  register write enable; = o_done AND rd != 0.
- o_rd_addr  output  ADDR_WIDTH  latched destination index.
- o_write_data  output  DATA_WIDTH  result; holds until next completion.

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers cleared. Reset mid-operation aborts with no o_done/o_write_en pulse.
- States: IDLE, CALC, FIX, DONE.
- Accept (IDLE or DONE, i_start=1):
  - Latch i_op, i_rd_addr, and operand magnitudes. Signed ops take two's-complement absolute values; abs(0x80000000) is 0x80000000 as unsigned.
  - Latch the quotient sign (rs1 sign XOR rs2 sign) and the remainder sign (rs1 sign).
- Special cases, resolved at accept; next state DONE, latency 1:
  - Divisor 0: quotient = all ones; remainder = rs1.
  - Signed overflow (DIV/REM, rs1=0x80000000, rs2=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- Normal case, next state CALC:
  - Counter loads DATA_WIDTH.
  - Each CALC cycle: shift {rem,quo} left 1; trial-subtract the divisor magnitude; if no borrow, keep the difference and set quo[0]=1. Decrement the counter.
  - Counter reaching 0 -> FIX.
- FIX: negate the quotient if the quotient sign is set (DIV only); negate the remainder if the remainder sign is set (REM only). Select quotient for DIV/DIVU, remainder for REM/REMU. -> DONE.
- DONE: o_done=1 for exactly one cycle, with o_write_data and o_rd_addr valid.
  - o_write_en=1 unless rd=0; o_done still pulses when rd=0.
  - Next state IDLE, or accept a new request in the same cycle (back-to-back).
- Latency: cycle of accept = cycle 0.
  - o_done in cycle DATA_WIDTH+2 (34) for the normal case.
  - o_done in cycle 1 for special cases.
- i_start while o_busy=1: ignored, with no effect on the operation in flight.
- Inputs are sampled only at accept; later changes have no effect.
- All arithmetic is modulo 2^DATA_WIDTH.

Optional Feature:
- Macro DIV_EARLY_OUT_EN.
- Defined: at accept, if the divisor magnitude > the dividend magnitude (unsigned compare, divisor != 0), skip CALC. Quotient = 0; remainder = rs1 unchanged (sign preserved). -> DONE; o_done in cycle 1.
- Undefined: that case takes the full 34-cycle path with identical results.

Test Plan:
- DIV rs1=20, rs2=0xFFFFFFFD (-3), rd=5 -> o_done in cycle 34, o_write_en=1, o_rd_addr=5, data 0xFFFFFFFA; REM same operands -> 0x00000002.
- DIVU 0xFFFFFFFF/2 -> 0x7FFFFFFF; REMU 0xFFFFFFFF/2 -> 0x00000001; o_busy high cycles 1-33.
- DIVU 7/0 -> 0xFFFFFFFF and REMU 7/0 -> 7, each with o_done in cycle 1.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0; both with o_done in cycle 1.
- DIV 100/7 with rd=0 -> o_done=1, o_write_en=0, data 14. Pulse i_start at cycle 10 -> ignored, result unchanged.
- Start DIVU 9/3, assert arst at cycle 15 -> no o_done; all outputs 0; next request accepted normally. With DIV_EARLY_OUT_EN, DIVU 3/9 -> data 0 in cycle 1.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Ports:
//   clk          - clock
//   arst         - synchronous active-high reset
//   i_start      - request, accepted in IDLE or DONE
//   i_op         - 00 DIV, 01 DIVU, 10 REM, 11 REMU
//   i_rs1_data   - dividend
//   i_rs2_data   - divisor
//   i_rd_addr    - destination register index
//   o_busy       - high in CALC or FIX
//   o_done       - one-cycle completion pulse
//   o_write_en   - o_done qualified by rd != 0
//   o_rd_addr    - latched destination index
//   o_write_data - result, held until the next completion
// Build option: define DIV_EARLY_OUT_EN to finish in one cycle when the
// divisor magnitude exceeds the dividend magnitude.
module div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  i_start,
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_write_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic [DATA_WIDTH-1:0] o_write_data
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [DATA_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  qsgn_q, qsgn_d, rsgn_q, rsgn_d;

    logic                  signed_op, s1, s2, div0, ovf, early, nb;
    logic [DATA_WIDTH-1:0] mag1, mag2;
    logic [DATA_WIDTH:0]   sh, diff;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        qsgn_d    = qsgn_q;
        rsgn_d    = rsgn_q;
        signed_op = ~i_op[0];
        s1        = signed_op & i_rs1_data[DATA_WIDTH-1];
        s2        = signed_op & i_rs2_data[DATA_WIDTH-1];
        // abs of the most negative value wraps back to itself, which is
        // exactly its magnitude when read as unsigned
        mag1      = s1 ? -i_rs1_data : i_rs1_data;
        mag2      = s2 ? -i_rs2_data : i_rs2_data;
        div0      = i_rs2_data == '0;
        ovf       = signed_op && i_rs1_data == MIN_NEG && i_rs2_data == '1;
`ifdef DIV_EARLY_OUT_EN
        early     = !div0 && mag2 > mag1;
`else
        early     = 1'b0;
`endif
        // partial remainder needs one extra bit: divisors above 2^(W-1)
        // can see a shifted remainder that overflows W bits
        sh        = {rem_q, quo_q[DATA_WIDTH-1]};
        diff      = sh - {1'b0, dvs_q};
        nb        = ~diff[DATA_WIDTH];
        case (state_q)
            CALC: begin
                rem_d = nb ? diff[DATA_WIDTH-1:0] : sh[DATA_WIDTH-1:0];
                quo_d = {quo_q[DATA_WIDTH-2:0], nb};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1))
                    state_d = FIX;
            end
            FIX: begin
                res_d   = op_q[1] ? (rsgn_q ? -rem_q : rem_q) : (qsgn_q ? -quo_q : quo_q);
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
                if (i_start) begin
                    op_d   = i_op;
                    rd_d   = i_rd_addr;
                    qsgn_d = s1 ^ s2;
                    rsgn_d = s1;
                    if (div0 || ovf || early) begin
                        res_d   = i_op[1] ? (ovf ? '0 : i_rs1_data)
                                          : (div0 ? '1 : (ovf ? MIN_NEG : '0));
                        state_d = DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = mag1;
                        dvs_d   = mag2;
                        cnt_d   = CW'(DATA_WIDTH);
                        state_d = CALC;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state_q <= IDLE;
            op_q    <= '0;
            rd_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            qsgn_q  <= 1'b0;
            rsgn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            qsgn_q  <= qsgn_d;
            rsgn_q  <= rsgn_d;
        end
    end

    assign o_busy       = state_q == CALC || state_q == FIX;
    assign o_done       = state_q == DONE;
    assign o_write_en   = o_done && rd_q != '0;
    assign o_rd_addr    = rd_q;
    assign o_write_data = res_q;
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table plus reset, busy-ignore and back-to-back sequences.
module tb_div_unit;
    localparam logic [1:0] DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3;
`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_EN = 1'b1;
`else
    localparam bit EARLY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        i_start = 1'b0;
    logic [1:0]  i_op = '0;
    logic [31:0] i_rs1_data = '0, i_rs2_data = '0;
    logic [4:0]  i_rd_addr = '0;
    logic        o_busy, o_done, o_write_en;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_write_data;

    int n_vec = 0, n_err = 0;

    div_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk), .arst(arst), .i_start(i_start), .i_op(i_op),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_rd_addr(i_rd_addr),
        .o_busy(o_busy), .o_done(o_done), .o_write_en(o_write_en),
        .o_rd_addr(o_rd_addr), .o_write_data(o_write_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        bit          spec;
        bit          early;
    } vec_t;

    function automatic vec_t mk(string nm, logic [1:0] op, logic [31:0] a, logic [31:0] b,
                                logic [4:0] rd, logic [31:0] exp, bit spec, bit early);
        vec_t v;
        v.name = nm; v.op = op; v.a = a; v.b = b; v.rd = rd; v.exp = exp;
        v.spec = spec; v.early = early;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        @(negedge clk);
        i_start = 1'b1; i_op = op; i_rs1_data = a; i_rs2_data = b; i_rd_addr = rd;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        i_op = 2'($urandom); i_rs1_data = $urandom; i_rs2_data = $urandom;
        i_rd_addr = 5'($urandom);
    endtask

    task automatic wait_done(input int lat0, output int lat, output bit busy_ok);
        lat = lat0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!o_done && !o_busy) busy_ok = 1'b0;
        end while (!o_done && lat < 200);
        if (o_busy) busy_ok = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t vt[$];
        int   lat, exp_lat, dc;
        bit   bok;

        vt.push_back(mk("div_20_m3",     DIV,  32'd20,       32'hFFFFFFFD, 5'd5,  32'hFFFFFFFA, 0, 0));
        vt.push_back(mk("rem_20_m3",     REM,  32'd20,       32'hFFFFFFFD, 5'd5,  32'h00000002, 0, 0));
        vt.push_back(mk("divu_max_2",    DIVU, 32'hFFFFFFFF, 32'd2,        5'd6,  32'h7FFFFFFF, 0, 0));
        vt.push_back(mk("remu_max_2",    REMU, 32'hFFFFFFFF, 32'd2,        5'd6,  32'h00000001, 0, 0));
        vt.push_back(mk("divu_7_0",      DIVU, 32'd7,        32'd0,        5'd1,  32'hFFFFFFFF, 1, 0));
        vt.push_back(mk("remu_7_0",      REMU, 32'd7,        32'd0,        5'd2,  32'h00000007, 1, 0));
        vt.push_back(mk("div_ovf",       DIV,  32'h80000000, 32'hFFFFFFFF, 5'd3,  32'h80000000, 1, 0));
        vt.push_back(mk("rem_ovf",       REM,  32'h80000000, 32'hFFFFFFFF, 5'd4,  32'h00000000, 1, 0));
        vt.push_back(mk("div_m7_2",      DIV,  32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFD, 0, 0));
        vt.push_back(mk("rem_m7_2",      REM,  32'hFFFFFFF9, 32'd2,        5'd8,  32'hFFFFFFFF, 0, 0));
        vt.push_back(mk("div_min_2",     DIV,  32'h80000000, 32'd2,        5'd9,  32'hC0000000, 0, 0));
        vt.push_back(mk("div_min_3",     DIV,  32'h80000000, 32'd3,        5'd10, 32'hD5555556, 0, 0));
        vt.push_back(mk("rem_min_3",     REM,  32'h80000000, 32'd3,        5'd11, 32'hFFFFFFFE, 0, 0));
        vt.push_back(mk("divu_max_msb",  DIVU, 32'hFFFFFFFF, 32'h80000000, 5'd12, 32'h00000001, 0, 0));
        vt.push_back(mk("remu_max_msb",  REMU, 32'hFFFFFFFF, 32'h80000000, 5'd13, 32'h7FFFFFFF, 0, 0));
        vt.push_back(mk("divu_msb_big",  DIVU, 32'h80000000, 32'h80000001, 5'd14, 32'h00000000, 0, 1));
        vt.push_back(mk("remu_msb_big",  REMU, 32'h80000000, 32'h80000001, 5'd15, 32'h80000000, 0, 1));
        vt.push_back(mk("div_m20_m3",    DIV,  32'hFFFFFFEC, 32'hFFFFFFFD, 5'd16, 32'h00000006, 0, 0));
        vt.push_back(mk("rem_m20_m3",    REM,  32'hFFFFFFEC, 32'hFFFFFFFD, 5'd17, 32'hFFFFFFFE, 0, 0));
        vt.push_back(mk("div_m5_0",      DIV,  32'hFFFFFFFB, 32'd0,        5'd18, 32'hFFFFFFFF, 1, 0));
        vt.push_back(mk("rem_m5_0",      REM,  32'hFFFFFFFB, 32'd0,        5'd19, 32'hFFFFFFFB, 1, 0));
        vt.push_back(mk("divu_3_9",      DIVU, 32'd3,        32'd9,        5'd20, 32'h00000000, 0, 1));
        vt.push_back(mk("remu_3_9",      REMU, 32'd3,        32'd9,        5'd21, 32'h00000003, 0, 1));
        vt.push_back(mk("div_m3_7",      DIV,  32'hFFFFFFFD, 32'd7,        5'd22, 32'h00000000, 0, 1));
        vt.push_back(mk("rem_m3_7",      REM,  32'hFFFFFFFD, 32'd7,        5'd23, 32'hFFFFFFFD, 0, 1));
        vt.push_back(mk("div_7_m1",      DIV,  32'd7,        32'hFFFFFFFF, 5'd31, 32'hFFFFFFF9, 0, 0));

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_done", 32'(o_done), 32'd0);
        chk("reset_we", 32'(o_write_en), 32'd0);
        chk("reset_rd", 32'(o_rd_addr), 32'd0);
        chk("reset_data", o_write_data, 32'd0);
        arst = 1'b0;

        foreach (vt[i]) begin
            exp_lat = (vt[i].spec || (vt[i].early && EARLY_EN)) ? 1 : 34;
            issue(vt[i].op, vt[i].a, vt[i].b, vt[i].rd);
            wait_done(0, lat, bok);
            chk({vt[i].name, "_data"}, o_write_data, vt[i].exp);
            chk({vt[i].name, "_lat"}, 32'(lat), 32'(exp_lat));
            chk({vt[i].name, "_we"}, 32'(o_write_en), 32'(vt[i].rd != 5'd0));
            chk({vt[i].name, "_rd"}, 32'(o_rd_addr), 32'(vt[i].rd));
            chk({vt[i].name, "_busy"}, 32'(bok), 32'd1);
            @(negedge clk);
            chk({vt[i].name, "_pulse"}, 32'(o_done), 32'd0);
        end

        // rd=0 with a stray start mid-operation
        issue(DIV, 32'd100, 32'd7, 5'd0);
        repeat (10) @(negedge clk);
        i_start = 1'b1; i_op = DIVU; i_rs1_data = 32'd1; i_rs2_data = 32'd1; i_rd_addr = 5'd3;
        @(posedge clk);
        #1 i_start = 1'b0;
        wait_done(10, lat, bok);
        chk("rd0_done", 32'(o_done), 32'd1);
        chk("rd0_lat", 32'(lat), 32'd34);
        chk("rd0_data", o_write_data, 32'd14);
        chk("rd0_we", 32'(o_write_en), 32'd0);
        chk("rd0_rd", 32'(o_rd_addr), 32'd0);
        chk("rd0_busy", 32'(bok), 32'd1);
        @(negedge clk);
        chk("rd0_pulse", 32'(o_done), 32'd0);

        // back-to-back accept in the DONE cycle
        issue(DIVU, 32'd7, 32'd0, 5'd9);
        wait_done(0, lat, bok);
        chk("b2b_first_lat", 32'(lat), 32'd1);
        chk("b2b_first_data", o_write_data, 32'hFFFFFFFF);
        i_start = 1'b1; i_op = REMU; i_rs1_data = 32'd7; i_rs2_data = 32'd0; i_rd_addr = 5'd10;
        @(posedge clk);
        #1 i_start = 1'b0;
        wait_done(0, lat, bok);
        chk("b2b_second_lat", 32'(lat), 32'd1);
        chk("b2b_second_data", o_write_data, 32'd7);
        chk("b2b_second_rd", 32'(o_rd_addr), 32'd10);

        // reset mid-operation aborts silently
        issue(DIVU, 32'd9, 32'd3, 5'd7);
        repeat (15) @(negedge clk);
        arst = 1'b1;
        @(negedge clk);
        arst = 1'b0;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_we", 32'(o_write_en), 32'd0);
        chk("abort_rd", 32'(o_rd_addr), 32'd0);
        chk("abort_data", o_write_data, 32'd0);
        dc = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_done) dc++;
        end
        chk("abort_no_done", 32'(dc), 32'd0);
        issue(DIVU, 32'd9, 32'd3, 5'd7);
        wait_done(0, lat, bok);
        chk("after_abort_lat", 32'(lat), 32'd34);
        chk("after_abort_data", o_write_data, 32'd3);
        chk("after_abort_we", 32'(o_write_en), 32'd1);
        chk("after_abort_rd", 32'(o_rd_addr), 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
